// File: rtl/temp_conv_pkg.sv
// Shared constants and types for the thermostat Celsius/Fahrenheit conversion blocks.
package temp_conv_pkg;

  localparam int unsigned F_OFFSET    = 32;
  localparam int unsigned F_MAX       = 491;
  localparam int unsigned C_MAX       = 255;
  localparam int unsigned DIV_DIVISOR = 9;
  localparam int unsigned ROUND_BIAS  = 8;
  localparam int unsigned F_TO_C_MUL  = 5;

  // Celsius-to-Fahrenheit direction: F = C*9/5 + 32
  localparam int unsigned C_TO_F_MUL    = 9;
  localparam int unsigned C_TO_F_DIV    = 5;
  localparam int unsigned C_TO_F_OFFSET = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } conv_state_t;

endpackage

// File: rtl/restoring_div_const.sv
// Iterative restoring divider by a constant: one quotient bit per cycle, MSB first.
module restoring_div_const #(
  parameter int unsigned WIDTH   = 12,
  parameter int unsigned DIVISOR = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] dividend,
  output logic [WIDTH-1:0] quotient,
  output logic             done
);

  localparam int unsigned RW = $clog2(DIVISOR) + 1;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [RW-1:0]    rem_r;
  logic [RW-1:0]    trial;
  logic [RW-1:0]    rem_next;
  logic [WIDTH-1:0] dvd_r;
  logic [WIDTH-1:0] quo_r;
  logic [CW-1:0]    count_r;
  logic             busy_r;
  logic             fits;
  logic             last;

  // quotient includes the bit resolved this cycle, so it is final while done is high
  always_comb begin
    trial    = {rem_r[RW-2:0], dvd_r[WIDTH-1]};
    fits     = (trial >= RW'(DIVISOR));
    rem_next = fits ? (trial - RW'(DIVISOR)) : trial;
    quotient = {quo_r[WIDTH-2:0], fits};
    last     = (count_r == CW'(WIDTH - 1));
    done     = busy_r & last;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_r   <= '0;
      dvd_r   <= '0;
      quo_r   <= '0;
      count_r <= '0;
      busy_r  <= 1'b0;
    end else if (load) begin
      rem_r   <= '0;
      dvd_r   <= dividend;
      quo_r   <= '0;
      count_r <= '0;
      busy_r  <= 1'b1;
    end else if (busy_r) begin
      rem_r   <= rem_next;
      dvd_r   <= {dvd_r[WIDTH-2:0], 1'b0};
      quo_r   <= quotient;
      count_r <= last ? '0 : (count_r + CW'(1));
      if (last) busy_r <= 1'b0;
    end
  end

endmodule

// File: rtl/fahrenheit_to_celsius_seq.sv
// Fahrenheit-to-Celsius converter, ceil((F-32)*5/9) with clamping, valid/ready on both sides.
module fahrenheit_to_celsius_seq
  import temp_conv_pkg::*;
#(
  parameter int unsigned DIV_ITERS = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] fahrenheit_value,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  celsius_value,
  output logic        underflow,
  output logic        overflow,
  output logic        out_valid,
  input  logic        out_ready
);

  conv_state_t           state_r;
  logic signed [16:0]    diff;
  logic [DIV_ITERS-1:0]  dividend_next;
  logic [DIV_ITERS-1:0]  quotient;
  logic                  uf_next;
  logic                  of_next;
  logic                  uf_pend_r;
  logic                  of_pend_r;
  logic                  accept;
  logic                  div_done;
  logic                  unused_quot_hi;

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign accept    = in_valid & in_ready;

  // +ROUND_BIAS turns the divider's floor into ceil((F-32)*5/9)
  always_comb begin
    diff          = signed'({1'b0, fahrenheit_value}) - signed'(17'(F_OFFSET));
    uf_next       = 1'b0;
    of_next       = 1'b0;
    dividend_next = '0;
    if (diff < 0) begin
      uf_next = 1'b1;
    end else if (fahrenheit_value > 16'(F_MAX)) begin
      of_next       = 1'b1;
      dividend_next = DIV_ITERS'(C_MAX * DIV_DIVISOR + ROUND_BIAS);
    end else begin
      dividend_next = DIV_ITERS'(diff[DIV_ITERS-1:0] * DIV_ITERS'(F_TO_C_MUL))
                    + DIV_ITERS'(ROUND_BIAS);
    end
  end

  restoring_div_const #(
    .WIDTH   (DIV_ITERS),
    .DIVISOR (DIV_DIVISOR)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .dividend (dividend_next),
    .quotient (quotient),
    .done     (div_done)
  );

  assign unused_quot_hi = ^quotient[DIV_ITERS-1:8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      uf_pend_r     <= 1'b0;
      of_pend_r     <= 1'b0;
      celsius_value <= '0;
      underflow     <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: if (in_valid) begin
          state_r   <= DIV;
          uf_pend_r <= uf_next;
          of_pend_r <= of_next;
        end
        DIV: if (div_done) begin
          state_r       <= DONE;
          celsius_value <= quotient[7:0];
          underflow     <= uf_pend_r;
          overflow      <= of_pend_r;
        end
        DONE: if (out_ready) state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fahrenheit_to_celsius_seq.sv
// Directed scoreboard bench for fahrenheit_to_celsius_seq.
module tb_fahrenheit_to_celsius_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] fahrenheit_value;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  celsius_value;
  logic        underflow;
  logic        overflow;
  logic        out_valid;
  logic        out_ready;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int c;
    bit uf;
    bit of;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  fahrenheit_to_celsius_seq #(.DIV_ITERS(12)) dut (
    .clk              (clk),
    .rst              (rst),
    .fahrenheit_value (fahrenheit_value),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .celsius_value    (celsius_value),
    .underflow        (underflow),
    .overflow         (overflow),
    .out_valid        (out_valid),
    .out_ready        (out_ready)
  );

  // Smallest C with 9*C >= 5*(F-32), clamped to 0..255
  function automatic exp_t model(input int f);
    exp_t e;
    int d;
    e.c = 0; e.uf = 0; e.of = 0;
    if (f < 32) e.uf = 1;
    else if (f > 491) begin e.of = 1; e.c = 255; end
    else begin
      d = f - 32;
      while (9 * e.c < 5 * d) e.c++;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0] f);
    int n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    fahrenheit_value = f;
    in_valid = 1'b1;
    sb.push_back(model(int'(f)));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic await_result(input string tag);
    int lat = 0;
    exp_t e;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    chk({tag, "_latency"}, lat, 12);
    if (sb.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_celsius"}, {24'd0, celsius_value}, e.c);
      chk({tag, "_underflow"}, {31'd0, underflow}, {31'd0, e.uf});
      chk({tag, "_overflow"}, {31'd0, overflow}, {31'd0, e.of});
    end
  endtask

  task automatic finish_xfer(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_out_valid_low"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_in_ready_high"}, {31'd0, in_ready}, 32'd1);
  endtask

  typedef struct {
    logic [15:0] f;
    int          c;
    bit          uf;
    bit          of;
  } vec_t;

  vec_t vecs[9] = '{
    '{16'd212,   100, 1'b0, 1'b0},
    '{16'd98,    37,  1'b0, 1'b0},
    '{16'd32,    0,   1'b0, 1'b0},
    '{16'd491,   255, 1'b0, 1'b0},
    '{16'd20,    0,   1'b1, 1'b0},
    '{16'd600,   255, 1'b0, 1'b1},
    '{16'd31,    0,   1'b1, 1'b0},
    '{16'd492,   255, 1'b0, 1'b1},
    '{16'hFFFF,  255, 1'b0, 1'b1}
  };

  initial begin
    int seen;
    rst = 1'b1;
    fahrenheit_value = '0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_celsius", {24'd0, celsius_value}, 32'd0);
    chk("rst_flags", {30'd0, underflow, overflow}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed values, including the clamping boundaries
    foreach (vecs[i]) begin
      send(vecs[i].f);
      await_result($sformatf("dir_F%0d", vecs[i].f));
      chk($sformatf("dir_tbl_F%0d", vecs[i].f), {24'd0, celsius_value}, vecs[i].c);
      chk($sformatf("dir_tbl_flags_F%0d", vecs[i].f), {30'd0, underflow, overflow},
          {30'd0, vecs[i].uf, vecs[i].of});
      finish_xfer("dir");
    end

    // C -> F -> C round trip over the whole Celsius range
    for (int c = 0; c < 256; c++) begin
      send(16'((9 * c) / 5 + 32));
      await_result("rt");
      chk($sformatf("rt_C%0d", c), {24'd0, celsius_value}, c);
      finish_xfer("rt");
    end

    // Backpressure: DONE holds, a new in_valid is ignored
    out_ready = 1'b0;
    send(16'd98);
    await_result("bp");
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin fahrenheit_value = 16'd212; in_valid = 1'b1; end
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_celsius", {24'd0, celsius_value}, 32'd37);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    finish_xfer("bp");
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("bp_no_extra_result", seen, 0);

    // Reset while dividing aborts the conversion
    fahrenheit_value = 16'd212;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("abort_no_result", seen, 0);
    chk("abort_idle", {31'd0, in_ready}, 32'd1);
    send(16'd50);
    await_result("post_rst");
    chk("post_rst_F50", {24'd0, celsius_value}, 32'd10);
    finish_xfer("post_rst");
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
